// File: rtl/csa_resolver_if.sv
// rtl/csa_resolver_if.sv - handshake bundle for the carry-save resolver
interface csa_resolver_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] result;

    modport master (
        output in_valid,
        output sum_in,
        output carry_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result
    );

    modport slave (
        input  in_valid,
        input  sum_in,
        input  carry_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result
    );
endinterface

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - digit-serial carry-propagate stage for a carry-save pair
module csa_resolver #(
    parameter int WIDTH = 16,   // must be a multiple of DIGIT and at least 2
    parameter int DIGIT = 4
) (
    input logic          clk,
    input logic          rst_n,
    csa_resolver_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cy;
    logic             top_c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH+1:0] res;
    logic             accept;
    logic             last;
    logic [DIGIT-1:0] a_slice;
    logic [DIGIT-1:0] b_slice;
    logic [DIGIT:0]   slice_sum;

    // Handshake flags are plain decodes of the state register, so neither
    // depends combinationally on in_valid or out_ready.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res;

    assign accept = bus.in_valid && (state == IDLE);
    assign last   = (cnt == LAST_SLICE);

    // One DIGIT-wide slice of the ripple add, selected by the slice counter.
    assign a_slice   = a[cnt*DIGIT +: DIGIT];
    assign b_slice   = b[cnt*DIGIT +: DIGIT];
    assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, cy};

    // State register; reset wins over any pending in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, walk N slices in RUN, hold in DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then write one result slice per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            cy    <= 1'b0;
            top_c <= 1'b0;
            a     <= '0;
            b     <= '0;
            res   <= '0;
        end else if (accept) begin
            // The carry vector is pre-shifted; its MSB falls off the top of B
            // and is folded back in beside the final carry-out.
            a     <= bus.sum_in;
            b     <= {bus.carry_in[WIDTH-2:0], 1'b0};
            top_c <= bus.carry_in[WIDTH-1];
            cnt   <= '0;
            cy    <= 1'b0;
            res   <= '0;
        end else if (state == RUN) begin
            res[cnt*DIGIT +: DIGIT] <= slice_sum[DIGIT-1:0];
            cy  <= slice_sum[DIGIT];
            cnt <= cnt + 1'b1;
            if (last) begin
                // Two carries of weight 2^WIDTH can meet here, hence the 2-bit sum.
                res[WIDTH+1:WIDTH] <= {1'b0, top_c} + {1'b0, slice_sum[DIGIT]};
            end
        end
    end
endmodule
